// File: rtl/game_status_controller_if.sv
// -----------------------------------------------------------------------------
// game_status_controller_if
//   Bundles the status controller's handshake and board inputs with its status
//   outputs.
//   master : move/checker side; drives start, move_done, matrix, can_move and
//            observes the status flags.
//   slave  : game_status_controller; consumes the inputs, drives the status.
//   Signals:
//     start           one-cycle pulse, begin or restart a game
//     move_done       one-cycle pulse, board register just written
//     matrix          4x4 board of 12-bit cells, 0 = empty
//     can_move        checker flag, 1 = some direction still changes the board
//     playing         game in progress (PLAY/SETTLE/EVAL)
//     busy            evaluation pending (SETTLE/EVAL); no moves allowed
//     win, lose       sticky result flags
//     game_over_pulse one-cycle pulse when a game result is decided
//     move_count      moves accepted in the current game (saturating)
// -----------------------------------------------------------------------------
interface game_status_controller_if #(
    parameter int CNT_W = 16
);
    logic                    start;
    logic                    move_done;
    logic [3:0][3:0][11:0]   matrix;
    logic                    can_move;
    logic                    playing;
    logic                    busy;
    logic                    win;
    logic                    lose;
    logic                    game_over_pulse;
    logic [CNT_W-1:0]        move_count;

    modport master (
        output start, move_done, matrix, can_move,
        input  playing, busy, win, lose, game_over_pulse, move_count
    );

    modport slave (
        input  start, move_done, matrix, can_move,
        output playing, busy, win, lose, game_over_pulse, move_count
    );
endinterface

// File: rtl/game_status_controller.sv
// -----------------------------------------------------------------------------
// game_status_controller
//   Game-phase FSM sitting after the 2048 move-possibility checker. After each
//   completed move it waits SETTLE_CYCLES for the board to settle, then spends
//   one EVAL cycle deciding win / lose / continue. Keeps a saturating move
//   counter and sticky win/lose flags. All outputs come from registers.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  game_status_controller_if.slave (start, move_done, matrix,
//          can_move in; playing, busy, win, lose, game_over_pulse,
//          move_count out)
//
//   Parameters:
//     WIN_VALUE      tile value that wins (compared against 12-bit cells)
//     SETTLE_CYCLES  wait after move_done before evaluation, 0..15
//     CNT_W          width of move_count
//
//   Optional build macro GAME_CONTINUE_AFTER_WIN_EN:
//     a winning evaluation sets win and pulses once, then play continues;
//     later evaluations skip the win check, and cells >= WIN_VALUE count as
//     a win. Without the macro a cell equal to WIN_VALUE ends the game in WIN.
// -----------------------------------------------------------------------------
module game_status_controller #(
    parameter int WIN_VALUE     = 2048,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    game_status_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_SETTLE,
        S_EVAL,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [11:0]      WIN_CELL    = 12'(WIN_VALUE);
    // The counter is loaded with SETTLE_CYCLES-1 so that SETTLE lasts exactly
    // SETTLE_CYCLES cycles; the zero case bypasses SETTLE entirely.
    localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] move_count_q, move_count_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             pulse_q, pulse_d;
    logic             win_cell;

    // Any cell on the board meets the winning condition.
    always_comb begin
        win_cell = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
`ifdef GAME_CONTINUE_AFTER_WIN_EN
                if (bus.matrix[r][c] >= WIN_CELL) win_cell = 1'b1;
`else
                if (bus.matrix[r][c] == WIN_CELL) win_cell = 1'b1;
`endif
            end
        end
    end

    // NOTE: every signal gets its hold value before the case so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        move_count_d = move_count_q;
        win_d        = win_q;
        lose_d       = lose_q;
        pulse_d      = 1'b0;

        if (bus.start) begin
            // start overrides any pending move or evaluation.
            state_d      = S_PLAY;
            settle_cnt_d = 4'd0;
            move_count_d = '0;
            win_d        = 1'b0;
            lose_d       = 1'b0;
        end else begin
            unique case (state_q)
                S_PLAY: begin
                    if (bus.move_done) begin
                        if (move_count_q != CNT_MAX) move_count_d = move_count_q + 1'b1;
                        if (SETTLE_CYCLES == 0) begin
                            state_d = S_EVAL;
                        end else begin
                            state_d      = S_SETTLE;
                            settle_cnt_d = SETTLE_LOAD;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == 4'd0) state_d = S_EVAL;
                    else                      settle_cnt_d = settle_cnt_q - 1'b1;
                end
                S_EVAL: begin
`ifdef GAME_CONTINUE_AFTER_WIN_EN
                    // Win is announced once per game; afterwards only lose matters.
                    if (win_cell && !win_q) begin
                        state_d = S_PLAY;
                        win_d   = 1'b1;
                        pulse_d = 1'b1;
                    end else
`else
                    if (win_cell) begin
                        state_d = S_WIN;
                        win_d   = 1'b1;
                        pulse_d = 1'b1;
                    end else
`endif
                    if (!bus.can_move) begin
                        state_d = S_LOSE;
                        lose_d  = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
                default: ; // IDLE, WIN, LOSE: wait for start
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= 4'd0;
            move_count_q <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            move_count_q <= move_count_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            pulse_q      <= pulse_d;
        end
    end

    assign bus.playing         = (state_q == S_PLAY) || (state_q == S_SETTLE) || (state_q == S_EVAL);
    assign bus.busy            = (state_q == S_SETTLE) || (state_q == S_EVAL);
    assign bus.win             = win_q;
    assign bus.lose            = lose_q;
    assign bus.game_over_pulse = pulse_q;
    assign bus.move_count      = move_count_q;

endmodule
